// File: rtl/sonar_ping_tx_pkg.sv
// Shared definitions for the sonar transmit block: register map, FSM states,
// CTRL bit positions, reset defaults and small helpers.
package sonar_ping_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_BLANK  = 2'd2,
        ST_LISTEN = 2'd3
    } state_e;

    localparam logic [3:0] ADR_CTRL      = 4'd0;
    localparam logic [3:0] ADR_HALF_PER  = 4'd1;
    localparam logic [3:0] ADR_NCYCLES   = 4'd2;
    localparam logic [3:0] ADR_BLANK     = 4'd3;
    localparam logic [3:0] ADR_LISTEN_LO = 4'd4;
    localparam logic [3:0] ADR_LISTEN_HI = 4'd5;
    localparam logic [3:0] ADR_DEADTIME  = 4'd6;
    localparam logic [3:0] ADR_STATUS    = 4'd7;
    localparam logic [3:0] ADR_PING_CNT  = 4'd8;

    localparam int CTRL_START  = 0;
    localparam int CTRL_REPEAT = 1;
    localparam int CTRL_ABORT  = 2;

    localparam logic [15:0] HP_RST   = 16'd125;
    localparam logic [15:0] NCYC_RST = 16'd8;
    localparam logic [15:0] BLK_RST  = 16'd1000;
    localparam logic [31:0] LSN_RST  = 32'd100000;

    // Zero-length settings are treated as one cycle so no counter can run away.
    function automatic logic [15:0] max1_16(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    function automatic logic [31:0] max1_32(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/sonar_ping_tx_if.sv
// Register bus shared with the receive path: strobe, address, data, write
// enable, registered acknowledge and read data.
interface sonar_ping_tx_if;
    logic        wb_valid_i;
    logic [3:0]  wbs_adr_i;
    logic [15:0] wbs_dat_i;
    logic        wbs_strb_i;
    logic        wbs_ack_o;
    logic [15:0] wbs_dat_o;

    modport master (
        output wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/sonar_ping_tx_tone_gen.sv
// Tone generator: half-period and cycle counters plus dead-time insertion.
// Build option SONAR_TX_DIFF_EN adds the complementary tx_n_o leg.
module sonar_tone_gen
    import sonar_ping_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        en_i,
    input  logic [15:0] hp_i,
    input  logic [15:0] ncyc_i,
    input  logic [15:0] dt_i,
    output logic        tx_p_o,
`ifdef SONAR_TX_DIFF_EN
    output logic        tx_n_o,
`endif
    output logic        last_o
);

    logic [15:0] hp_eff_s;
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] half_q, half_d;
    logic        act_s;
    logic        tx_p_d;

    assign hp_eff_s = max1_16(hp_i);

    // Next counter values and next leg levels, so the legs can be registered
    // yet line up with the first BURST cycle.
    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        if (start_i) begin
            cnt_d  = 16'd0;
            half_d = 17'd0;
        end else if (en_i) begin
            if (cnt_q == hp_eff_s - 16'd1) begin
                cnt_d  = 16'd0;
                half_d = half_q + 17'd1;
            end else begin
                cnt_d  = cnt_q + 16'd1;
            end
        end else begin
            cnt_d  = 16'd0;
            half_d = 17'd0;
        end
        act_s  = en_i && (ncyc_i != 16'd0) && (cnt_d >= dt_i);
        tx_p_d = act_s && !half_d[0];
    end

    assign last_o = (ncyc_i == 16'd0) ||
                    ((half_q == {ncyc_i, 1'b0} - 17'd1) && (cnt_q == hp_eff_s - 16'd1));

    // Counter and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= 16'd0;
            half_q <= 17'd0;
            tx_p_o <= 1'b0;
`ifdef SONAR_TX_DIFF_EN
            tx_n_o <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            tx_p_o <= tx_p_d;
`ifdef SONAR_TX_DIFF_EN
            tx_n_o <= act_s && half_d[0];
`endif
        end
    end

endmodule

// File: rtl/sonar_ping_tx.sv
// Sonar ping transmitter: bus registers, per-ping shadows and the
// IDLE/BURST/BLANK/LISTEN sequencer. Option SONAR_TX_DIFF_EN: tx_n + dead time.
module sonar_ping_tx
    import sonar_ping_tx_pkg::*;
(
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    sonar_ping_tx_if.slave  bus,
    input  logic            echo_i,
    output logic            tx_p,
`ifdef SONAR_TX_DIFF_EN
    output logic            tx_n,
`endif
    output logic            mclear_o,
    output logic            blank_o,
    output logic            busy_o,
    output logic            done_o
);

    logic [15:0] hp_q, ncyc_q, blk_q;
    logic [31:0] lsn_q;
    logic        repeat_q;
    logic [15:0] ping_cnt_q;
    logic        echo_q;
    logic        ack_q;
    logic [15:0] rdat_q, rdat_s;
    state_e      state_q, state_d;
    logic [31:0] tmr_q;
    logic [15:0] sh_hp_q, sh_nc_q, sh_blk_q, sh_hp_d, sh_nc_d, sh_blk_d;
    logic [31:0] sh_lsn_q, sh_lsn_d;
    logic [15:0] dt_s, sh_dt_s;
    logic        mclear_q, blank_q, busy_q, done_q;
    logic        wr_s, wr_ctrl_s, start_s, abort_s;
    logic        entry_s, blk_end_s, lsn_end_s, listen_done_s, tone_last_s;

`ifdef SONAR_TX_DIFF_EN
    logic [15:0] dt_q, sh_dt_q, sh_dt_d;
    assign dt_s    = dt_q;
    assign sh_dt_d = entry_s ? dt_q : sh_dt_q;
    assign sh_dt_s = sh_dt_d;
`else
    assign dt_s    = 16'd0;
    assign sh_dt_s = 16'd0;
`endif

    assign wr_s      = bus.wb_valid_i && bus.wbs_strb_i;
    assign wr_ctrl_s = wr_s && (bus.wbs_adr_i == ADR_CTRL);
    assign start_s   = wr_ctrl_s && bus.wbs_dat_i[CTRL_START];
    assign abort_s   = wr_ctrl_s && bus.wbs_dat_i[CTRL_ABORT];

    assign blk_end_s = (tmr_q == {16'd0, max1_16(sh_blk_q)} - 32'd1);
    assign lsn_end_s = echo_i || (tmr_q == max1_32(sh_lsn_q) - 32'd1);

    // Sequencer next state; ABORT overrides everything, including START.
    always_comb begin
        state_d = state_q;
        if (abort_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (start_s)     state_d = ST_BURST;  else state_d = ST_IDLE;
                ST_BURST:  if (tone_last_s) state_d = ST_BLANK;  else state_d = ST_BURST;
                ST_BLANK:  if (blk_end_s)   state_d = ST_LISTEN; else state_d = ST_BLANK;
                ST_LISTEN: begin
                    if (lsn_end_s) state_d = repeat_q ? ST_BURST : ST_IDLE;
                    else           state_d = ST_LISTEN;
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    assign entry_s       = (state_d == ST_BURST) && (state_q != ST_BURST);
    assign listen_done_s = (state_q == ST_LISTEN) && lsn_end_s && !abort_s;

    assign sh_hp_d  = entry_s ? hp_q   : sh_hp_q;
    assign sh_nc_d  = entry_s ? ncyc_q : sh_nc_q;
    assign sh_blk_d = entry_s ? blk_q  : sh_blk_q;
    assign sh_lsn_d = entry_s ? lsn_q  : sh_lsn_q;

    sonar_tone_gen u_tone (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .start_i (entry_s),
        .en_i    (state_d == ST_BURST),
        .hp_i    (sh_hp_d),
        .ncyc_i  (sh_nc_d),
        .dt_i    (sh_dt_s),
        .tx_p_o  (tx_p),
`ifdef SONAR_TX_DIFF_EN
        .tx_n_o  (tx_n),
`endif
        .last_o  (tone_last_s)
    );

    // Read data multiplexer.
    always_comb begin
        case (bus.wbs_adr_i)
            ADR_CTRL:      rdat_s = {14'd0, repeat_q, 1'b0};
            ADR_HALF_PER:  rdat_s = hp_q;
            ADR_NCYCLES:   rdat_s = ncyc_q;
            ADR_BLANK:     rdat_s = blk_q;
            ADR_LISTEN_LO: rdat_s = lsn_q[15:0];
            ADR_LISTEN_HI: rdat_s = lsn_q[31:16];
            ADR_DEADTIME:  rdat_s = dt_s;
            ADR_STATUS:    rdat_s = {12'd0, state_q, echo_q, state_q != ST_IDLE};
            ADR_PING_CNT:  rdat_s = ping_cnt_q;
            default:       rdat_s = 16'd0;
        endcase
    end

    // Bus registers, acknowledge and read data.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            hp_q     <= HP_RST;
            ncyc_q   <= NCYC_RST;
            blk_q    <= BLK_RST;
            lsn_q    <= LSN_RST;
            repeat_q <= 1'b0;
`ifdef SONAR_TX_DIFF_EN
            dt_q     <= 16'd0;
`endif
            ack_q    <= 1'b0;
            rdat_q   <= 16'd0;
        end else begin
            ack_q <= bus.wb_valid_i;
            if (bus.wb_valid_i) rdat_q <= rdat_s;
            if (wr_s) begin
                case (bus.wbs_adr_i)
                    ADR_CTRL:      repeat_q     <= bus.wbs_dat_i[CTRL_REPEAT];
                    ADR_HALF_PER:  hp_q         <= bus.wbs_dat_i;
                    ADR_NCYCLES:   ncyc_q       <= bus.wbs_dat_i;
                    ADR_BLANK:     blk_q        <= bus.wbs_dat_i;
                    ADR_LISTEN_LO: lsn_q[15:0]  <= bus.wbs_dat_i;
                    ADR_LISTEN_HI: lsn_q[31:16] <= bus.wbs_dat_i;
`ifdef SONAR_TX_DIFF_EN
                    ADR_DEADTIME:  dt_q         <= bus.wbs_dat_i;
`endif
                    default: ;
                endcase
            end
        end
    end

    // Sequencer state, window timer, shadows, status and registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            tmr_q      <= 32'd0;
            sh_hp_q    <= HP_RST;
            sh_nc_q    <= NCYC_RST;
            sh_blk_q   <= BLK_RST;
            sh_lsn_q   <= LSN_RST;
`ifdef SONAR_TX_DIFF_EN
            sh_dt_q    <= 16'd0;
`endif
            ping_cnt_q <= 16'd0;
            echo_q     <= 1'b0;
            mclear_q   <= 1'b0;
            blank_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= ((state_d == state_q) &&
                         ((state_q == ST_BLANK) || (state_q == ST_LISTEN))) ? tmr_q + 32'd1 : 32'd0;
            sh_hp_q  <= sh_hp_d;
            sh_nc_q  <= sh_nc_d;
            sh_blk_q <= sh_blk_d;
            sh_lsn_q <= sh_lsn_d;
`ifdef SONAR_TX_DIFF_EN
            sh_dt_q  <= sh_dt_d;
`endif
            if (listen_done_s) ping_cnt_q <= ping_cnt_q + 16'd1;
            if (entry_s)
                echo_q <= 1'b0;
            else if ((state_q == ST_LISTEN) && echo_i && !abort_s)
                echo_q <= 1'b1;
            mclear_q <= entry_s;
            blank_q  <= (state_d == ST_BURST) || (state_d == ST_BLANK);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= listen_done_s;
        end
    end

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = rdat_q;
    assign mclear_o      = mclear_q;
    assign blank_o       = blank_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
